// File: rtl/phaser_quadrant_ctrl_pkg.sv
// Shared state encoding and default sizing for the phase shifter controller.
package phaser_quadrant_ctrl_pkg;

  localparam int DEF_PHASE_BITS = 8;
  localparam int DEF_PS_TIMEOUT = 1023;
  localparam int DEF_SETTLE_CYC = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CALC      = 3'd1,
    ST_STEP      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_QUAD      = 3'd4,
    ST_SETTLE    = 3'd5,
    ST_WAIT_LOCK = 3'd6
  } phaser_state_e;

endpackage

// File: rtl/phaser_quadrant_ctrl_step.sv
// One DCM fine-shift handshake: a single psen pulse, then wait for psdone or give up after PS_TIMEOUT clocks.
module phaser_quadrant_ctrl_step
  import phaser_quadrant_ctrl_pkg::*;
#(
  parameter int PS_TIMEOUT = DEF_PS_TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic go,
  input  logic inc,
  input  logic abort,
  input  logic psdone,
  output logic psen,
  output logic psincdec,
  output logic done,
  output logic timeout
);

  localparam int TW = $clog2(PS_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PS_TIMEOUT - 1);

  logic          pending;
  logic [TW-1:0] timer;

  // psdone wins over a timeout landing in the same clock; an abort swallows both.
  assign done    = pending & psdone & ~abort;
  assign timeout = pending & ~psdone & ~abort & (timer == TIMER_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      psen     <= 1'b0;
      psincdec <= 1'b0;
      pending  <= 1'b0;
      timer    <= '0;
    end else begin
      psen <= 1'b0;
      if (abort) begin
        pending <= 1'b0;
      end else if (go && !pending) begin
        psen     <= 1'b1;
        psincdec <= inc;
        pending  <= 1'b1;
        timer    <= '0;
      end else if (done || timeout) begin
        pending <= 1'b0;
      end else if (pending) begin
        timer <= timer + TW'(1);
      end
    end
  end

endmodule

// File: rtl/phaser_quadrant_ctrl.sv
// Phase shifter initiator: steps the DCM fine phase, then updates the hcycle/qcycle quadrant selects.
// Build option PHASER_AUTORESTORE_EN: re-apply the last target automatically after DCM lock is regained.
module phaser_quadrant_ctrl
  import phaser_quadrant_ctrl_pkg::*;
#(
  parameter int PHASE_BITS = DEF_PHASE_BITS,
  parameter int PS_TIMEOUT = DEF_PS_TIMEOUT,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [PHASE_BITS-1:0] phase_req,
  input  logic                  phase_fire,
  input  logic                  dcm_locked,
  input  logic                  dps_psdone,
  output logic                  dps_psen,
  output logic                  dps_psincdec,
  output logic                  hcycle,
  output logic                  qcycle,
  output logic [PHASE_BITS-1:0] phase_now,
  output logic                  busy,
  output logic                  ps_timeout,
  output logic                  req_dropped,
  output logic                  sump
);

  localparam int FW = PHASE_BITS - 2;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC);

  phaser_state_e         state, state_nx;
  logic [PHASE_BITS-1:0] target;
  logic [FW-1:0]         fine_pos;
  logic [FW-1:0]         target_fine;
  logic [SW-1:0]         settle_cnt;
  logic                  accept;
  logic                  step_go;
  logic                  step_done;
  logic                  step_timeout;

  function automatic logic [FW-1:0] fine_step(input logic [FW-1:0] pos, input logic up);
    return up ? pos + FW'(1) : pos - FW'(1);
  endfunction

  assign target_fine = target[FW-1:0];
  assign accept      = phase_fire && dcm_locked && (state == ST_IDLE);
  assign phase_now   = {hcycle, qcycle, fine_pos};

  phaser_quadrant_ctrl_step #(
    .PS_TIMEOUT (PS_TIMEOUT)
  ) u_step (
    .clock    (clock),
    .reset_n  (reset_n),
    .go       (step_go),
    .inc      (target_fine > fine_pos),
    .abort    (!dcm_locked),
    .psdone   (dps_psdone),
    .psen     (dps_psen),
    .psincdec (dps_psincdec),
    .done     (step_done),
    .timeout  (step_timeout)
  );

  // Loss of lock overrides every state: the DCM has been reset, so its offset is back to zero.
  always_comb begin
    state_nx = state;
    step_go  = 1'b0;
    if (!dcm_locked) begin
      state_nx = ST_WAIT_LOCK;
    end else begin
      case (state)
        ST_IDLE:      if (phase_fire) state_nx = ST_CALC;
        ST_CALC:      state_nx = (target_fine != fine_pos) ? ST_STEP : ST_QUAD;
        ST_STEP: begin
          step_go  = 1'b1;
          state_nx = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (step_done)         state_nx = ST_CALC;
          else if (step_timeout) state_nx = ST_IDLE;
        end
        ST_QUAD:      state_nx = ST_SETTLE;
        ST_SETTLE:    if (settle_cnt == SETTLE_LAST) state_nx = ST_IDLE;
        ST_WAIT_LOCK: begin
`ifdef PHASER_AUTORESTORE_EN
          state_nx = ST_CALC;
`else
          state_nx = ST_IDLE;
`endif
        end
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      target      <= '0;
      fine_pos    <= '0;
      hcycle      <= 1'b0;
      qcycle      <= 1'b0;
      settle_cnt  <= '0;
      ps_timeout  <= 1'b0;
      req_dropped <= 1'b0;
      sump        <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != ST_IDLE);
      sump  <= dps_psdone && (state != ST_WAIT_DONE);

      if (phase_fire && !accept) req_dropped <= 1'b1;
      if (accept) target <= phase_req;

      if (!dcm_locked)
        fine_pos <= '0;
      else if (state == ST_WAIT_DONE && step_done)
        fine_pos <= fine_step(fine_pos, dps_psincdec);

      if (dcm_locked && state == ST_WAIT_DONE && step_timeout) ps_timeout <= 1'b1;

      if (dcm_locked && state == ST_QUAD) begin
        hcycle <= target[PHASE_BITS-1];
        qcycle <= target[PHASE_BITS-2];
      end

      // One clock beyond SETTLE_CYC so the mux synchroniser has fully taken the new select before busy drops.
      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + SW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_phaser_quadrant_ctrl.sv
// Directed bench for phaser_quadrant_ctrl with a simple DCM psen/psdone responder.
module tb_phaser_quadrant_ctrl;

  localparam int SETTLE_CYC = 16;
  localparam int DCM_LAT    = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] phase_req;
  logic       phase_fire;
  logic       dcm_locked;
  logic       dps_psdone;
  logic       dps_psen;
  logic       dps_psincdec;
  logic       hcycle;
  logic       qcycle;
  logic [7:0] phase_now;
  logic       busy;
  logic       ps_timeout;
  logic       req_dropped;
  logic       sump;

  int n_vec  = 0;
  int n_miss = 0;
  int psen_cnt, inc_cnt, dec_cnt;
  int pend;
  logic withhold;
  logic [7:0] mdl_phase;
  int nb, qat, cyc, cur_f, exp_n;

  phaser_quadrant_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .phase_req    (phase_req),
    .phase_fire   (phase_fire),
    .dcm_locked   (dcm_locked),
    .dps_psdone   (dps_psdone),
    .dps_psen     (dps_psen),
    .dps_psincdec (dps_psincdec),
    .hcycle       (hcycle),
    .qcycle       (qcycle),
    .phase_now    (phase_now),
    .busy         (busy),
    .ps_timeout   (ps_timeout),
    .req_dropped  (req_dropped),
    .sump         (sump)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fire(input logic [7:0] v);
    @(negedge clock);
    phase_req  = v;
    phase_fire = 1'b1;
    @(negedge clock);
    phase_fire = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic clr_cnt();
    psen_cnt = 0;
    inc_cnt  = 0;
    dec_cnt  = 0;
  endtask

  // DCM model: answers each psen with a one-clock psdone DCM_LAT clocks later.
  initial begin
    dps_psdone = 1'b0;
    pend = 0;
    forever begin
      @(negedge clock);
      dps_psdone = 1'b0;
      if (dps_psen) begin
        psen_cnt++;
        if (dps_psincdec) inc_cnt++; else dec_cnt++;
        if (!withhold) pend = DCM_LAT;
      end
      if (!dcm_locked) pend = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) dps_psdone = 1'b1;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    phase_req  = 8'h00;
    phase_fire = 1'b0;
    dcm_locked = 1'b1;
    withhold   = 1'b0;
    clr_cnt();
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_phase_now", phase_now, 8'h00);
    chk("rst_psen", dps_psen, 0);
    chk("rst_quad", {hcycle, qcycle}, 2'b00);
    chk("rst_flags", {ps_timeout, req_dropped, sump}, 3'b000);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_idle", busy, 0);

    // 1: 0x00 -> 0x05, five increments
    clr_cnt();
    fire(8'h05);
    chk("t1_busy_rise", busy, 1);
    wait_idle("t1_idle", 400);
    chk("t1_psen_cnt", psen_cnt, 5);
    chk("t1_inc_cnt", inc_cnt, 5);
    chk("t1_phase_now", phase_now, 8'h05);

    // 2: 0x05 -> 0xC2, three decrements then both quadrants set
    clr_cnt();
    fire(8'hC2);
    wait_idle("t2_idle", 400);
    chk("t2_dec_cnt", dec_cnt, 3);
    chk("t2_psen_cnt", psen_cnt, 3);
    chk("t2_quad", {hcycle, qcycle}, 2'b11);
    chk("t2_phase_now", phase_now, 8'hC2);

    // back to 0x00
    clr_cnt();
    fire(8'h00);
    wait_idle("t2b_idle", 400);
    chk("t2b_phase_now", phase_now, 8'h00);

    // 3: 0x00 -> 0x40, quadrant only
    clr_cnt();
    fire(8'h40);
    nb  = 0;
    qat = 0;
    for (int i = 1; i <= 60; i++) begin
      if (busy) nb++;
      if (qcycle && qat == 0) qat = i;
      if (!busy) break;
      @(negedge clock);
    end
    chk("t3_busy_len", nb, SETTLE_CYC + 3);
    chk("t3_qcycle_at", qat, 3);
    chk("t3_no_psen", psen_cnt, 0);
    chk("t3_phase_now", phase_now, 8'h40);

    // 4: psdone withheld -> timeout, state unchanged, next fire accepted
    clr_cnt();
    withhold = 1'b1;
    fire(8'h41);
    cyc = 0;
    for (int i = 1; i <= 1200; i++) begin
      if (ps_timeout) begin
        cyc = i;
        break;
      end
      @(negedge clock);
    end
    chk("t4_timeout_window", (cyc >= 1020 && cyc <= 1030), 1);
    chk("t4_busy_low", busy, 0);
    chk("t4_phase_kept", phase_now, 8'h40);
    chk("t4_one_psen", psen_cnt, 1);
    withhold = 1'b0;
    repeat (3) @(negedge clock);
    clr_cnt();
    fire(8'h42);
    chk("t4_refire_busy", busy, 1);
    wait_idle("t4_refire_idle", 400);
    chk("t4_refire_phase", phase_now, 8'h42);
    chk("t4_timeout_sticky", ps_timeout, 1);

    // 5: lock lost at fine_pos=3 while stepping 0x42 -> 0x0A
    fire(8'h0A);
    for (int i = 0; i < 200; i++) begin
      if (phase_now[5:0] == 6'd3) break;
      @(negedge clock);
    end
    chk("t5_reach_fine3", phase_now[5:0], 3);
    dcm_locked = 1'b0;
    clr_cnt();
    repeat (10) @(negedge clock);
    chk("t5_psen_stopped", psen_cnt, 0);
    chk("t5_fine_zero", phase_now, 8'h40);
    chk("t5_busy_held", busy, 1);
    dcm_locked = 1'b1;
    @(negedge clock);
    wait_idle("t5_relock_idle", 400);
`ifdef PHASER_AUTORESTORE_EN
    mdl_phase = 8'h0A;
    chk("t5_restore_steps", inc_cnt, 10);
`else
    mdl_phase = 8'h40;
    chk("t5_no_steps", psen_cnt, 0);
`endif
    chk("t5_phase_now", phase_now, mdl_phase);

    // 6: second fire while busy is dropped, first request completes
    chk("t6_dropped_clear", req_dropped, 0);
    cur_f = int'(mdl_phase[5:0]);
    exp_n = (cur_f > 3) ? cur_f - 3 : 3 - cur_f;
    clr_cnt();
    fire(8'h43);
    repeat (4) @(negedge clock);
    fire(8'h80);
    chk("t6_dropped_set", req_dropped, 1);
    wait_idle("t6_idle", 600);
    chk("t6_phase_now", phase_now, 8'h43);
    chk("t6_psen_cnt", psen_cnt, exp_n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
